// File: rtl/mandelbrot_scanner.sv
// mandelbrot_scanner
// Sweeps a COLS x ROWS grid of 6.10 fixed-point points c = r + i*j, launches
// one iteration-core computation per pixel and stores each 4-bit iteration
// count in pixel memory.
//
// Ports
//   raw_clk, reset_n         clock, asynchronous active-low reset
//   go, abort                frame control (go sampled only in IDLE)
//   busy, done               frame in progress / one-cycle completion pulse
//   core_start               one-cycle launch pulse per pixel
//   core_r, core_i           point coordinates, held for the whole computation
//   core_busy, core_result   core handshake and iteration count
//   pix_we, pix_addr, pix_data   pixel memory write port
//
// state     | meaning
// IDLE      | waiting for go
// LAUNCH    | core_start pulse for the current pixel
// WAIT_ACK  | waiting for the core to raise core_busy
// WAIT_DONE | core computing; result captured when core_busy falls
// WRITE     | pixel write strobe
// ADVANCE   | step to the next column/row, or finish the frame
// DRAIN     | aborted; waiting for the uninterruptible core to finish
module mandelbrot_scanner #(
   parameter int          COLS    = 64,
   parameter int          ROWS    = 32,
   parameter logic [15:0] R_START = 16'hF800,
   parameter logic [15:0] I_START = 16'hFC00,
   parameter logic [15:0] R_STEP  = 16'd48,
   parameter logic [15:0] I_STEP  = 16'd64,
   parameter int          ADDR_W  = 11
) (
   input  logic              raw_clk,
   input  logic              reset_n,
   input  logic              go,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              core_start,
   output logic [15:0]       core_r,
   output logic [15:0]       core_i,
   input  logic              core_busy,
   input  logic [3:0]        core_result,
   output logic              pix_we,
   output logic [ADDR_W-1:0] pix_addr,
   output logic [3:0]        pix_data
);

   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [2:0] {
      IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, WRITE, ADVANCE, DRAIN
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          last_col, last_row;

   assign last_col = (col == CW'(COLS - 1));
   assign last_row = (row == RW'(ROWS - 1));

   always_ff @(posedge raw_clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      core_start = 1'b0;
      pix_we     = 1'b0;
      case (state)
         IDLE:      if (go) state_nxt = LAUNCH;
         LAUNCH: begin
            if (abort) state_nxt = DRAIN;
            else begin
               core_start = 1'b1;
               state_nxt  = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (abort)          state_nxt = DRAIN;
            else if (core_busy) state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (abort)           state_nxt = DRAIN;
            else if (!core_busy) state_nxt = WRITE;
         end
         WRITE: begin
            if (abort) state_nxt = IDLE;
            else begin
               pix_we    = 1'b1;
               state_nxt = ADVANCE;
            end
         end
         ADVANCE: begin
            if (abort || (last_col && last_row)) state_nxt = IDLE;
            else                                 state_nxt = LAUNCH;
         end
         DRAIN:     if (!core_busy) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Coordinates and the pixel address are stepped incrementally; pix_addr
   // tracks row*COLS+col without a multiplier. Nothing here moves between
   // LAUNCH and WAIT_DONE, so the core sees stable coordinates.
   always_ff @(posedge raw_clk or negedge reset_n) begin
      if (!reset_n) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         col      <= '0;
         row      <= '0;
         core_r   <= R_START;
         core_i   <= I_START;
         pix_addr <= '0;
         pix_data <= '0;
      end else begin
         busy <= (state_nxt != IDLE);
         done <= (state == ADVANCE) && !abort && last_col && last_row;
         case (state)
            IDLE: begin
               if (go) begin
                  col      <= '0;
                  row      <= '0;
                  pix_addr <= '0;
                  core_r   <= R_START;
                  core_i   <= I_START;
               end
            end
            WAIT_DONE: begin
               if (!abort && !core_busy) pix_data <= core_result;
            end
            ADVANCE: begin
               if (!abort) begin
                  if (!last_col) begin
                     col      <= col + CW'(1);
                     core_r   <= core_r + R_STEP;
                     pix_addr <= pix_addr + ADDR_W'(1);
                  end else if (!last_row) begin
                     col      <= '0;
                     row      <= row + RW'(1);
                     core_r   <= R_START;
                     core_i   <= core_i + I_STEP;
                     pix_addr <= pix_addr + ADDR_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
